stopwatch_ctrl: RTL and testbench

Control FSM that sequences the stopwatch BCD time counter. Two raw push-buttons are synchronised and debounced into single-cycle press events. A prescaler divides the system clock into a 1 Hz count-enable pulse. The block drives the counter's enable and clear inputs, plus a lap-hold signal for the display path. It sits between the board buttons and the MM:SS counter/display datapath.

---
 rtl/stopwatch_ctrl.sv | 169 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: debounced buttons, 1 Hz prescaler and mode FSM.
// Ports:
//   clk, reset_n                  : clock, async active-low reset
//   btn_start_stop, btn_lap_reset : raw active-high buttons
//   count_en, count_clr           : counter enable tick / clear pulse
//   lap_latch, display_hold       : lap capture pulse / display hold level
//   state                         : IDLE=00 RUN=01 PAUSE=10 LAP=11
module stopwatch_ctrl #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 500_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_start_stop,
    input  logic       btn_lap_reset,
    output logic       count_en,
    output logic       count_clr,
    output logic       lap_latch,
    output logic       display_hold,
    output logic [1:0] state
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        LAP   = 2'b11
    } state_e;

    // Bit 0 = start/stop, bit 1 = lap/reset.
    logic [1:0]         btn_raw;
    logic [1:0]         sync1_q;
    logic [1:0]         sync2_q;
    logic [1:0]         level_q;
    logic [1:0]         level_d;
    logic [1:0]         level_dly_q;
    logic [1:0]         press_q;
    logic [1:0][DW-1:0] db_cnt_q;
    logic [1:0][DW-1:0] db_cnt_d;

    assign btn_raw = {btn_lap_reset, btn_start_stop};

    // A level change is accepted only after DEBOUNCE_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            level_d[i]  = level_q[i];
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            press_q     <= '0;
            db_cnt_q    <= '0;
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            press_q     <= level_q & ~level_dly_q;
            db_cnt_q    <= db_cnt_d;
        end
    end

    logic ss_ev;
    logic lr_ev;

    assign ss_ev = press_q[0];
    assign lr_ev = press_q[1];

    state_e        state_q;
    state_e        state_d;
    logic          lap_d;
    logic          clr_d;
    logic          en_d;
    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;

    // Start/stop wins over lap/reset when both fire in one cycle.
    always_comb begin
        state_d = state_q;
        lap_d   = 1'b0;
        clr_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_ev) state_d = RUN;
            end
            RUN: begin
                if (ss_ev) begin
                    state_d = PAUSE;
                end else if (lr_ev) begin
                    state_d = LAP;
                    lap_d   = 1'b1;
                end
            end
            LAP: begin
                if (ss_ev) begin
                    state_d = PAUSE;
                end else if (lr_ev) begin
                    state_d = RUN;
                end
            end
            PAUSE: begin
                if (ss_ev) begin
                    state_d = RUN;
                end else if (lr_ev) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // PAUSE freezes the prescaler so the fractional second survives.
    always_comb begin
        pre_d = pre_q;
        unique case (1'b1)
            (state_q == IDLE):  pre_d = '0;
            (state_q == PAUSE): pre_d = pre_q;
            default: begin
                pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
            end
        endcase
    end

    // A tick falling on the edge that leaves RUN/LAP is dropped.
    assign en_d = (state_q inside {RUN, LAP}) &&
                  (pre_q == PRE_LAST) &&
                  (state_d inside {RUN, LAP});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            pre_q        <= '0;
            count_en     <= 1'b0;
            count_clr    <= 1'b0;
            lap_latch    <= 1'b0;
            display_hold <= 1'b0;
        end else begin
            state_q      <= state_d;
            pre_q        <= pre_d;
            count_en     <= en_d;
            count_clr    <= clr_d;
            lap_latch    <= lap_d;
            display_hold <= (state_d == LAP);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Testbench for stopwatch_ctrl with TICK_DIV=4, DEBOUNCE_CYCLES=3.
// Scoreboard of expected event cycles, compared as outputs appear.
module tb_stopwatch_ctrl;

    localparam int TD = 4;
    localparam int DB = 3;

    typedef struct {
        int         c;
        logic [1:0] v;
    } st_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       btn_ss = 1'b0;
    logic       btn_lr = 1'b0;
    logic       count_en;
    logic       count_clr;
    logic       lap_latch;
    logic       display_hold;
    logic [1:0] state;

    int  cyc = 0;
    int  errors = 0;
    int  checks = 0;
    int  n_st = 0;
    int  last_en = -1;
    int  next_en = 0;
    int  rem = 0;
    bit  running = 1'b0;

    int  exp_en_q[$];
    int  exp_lap_q[$];
    int  exp_clr_q[$];
    st_t exp_st_q[$];

    logic [1:0] prev_state = 2'b00;
    logic       prev_en = 1'b0;
    int         m_e;
    st_t        m_s;

    stopwatch_ctrl #(
        .TICK_DIV(TD),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .btn_start_stop(btn_ss),
        .btn_lap_reset(btn_lr),
        .count_en(count_en),
        .count_clr(count_clr),
        .lap_latch(lap_latch),
        .display_hold(display_hold),
        .state(state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: pop expected event cycles as the DUT emits events.
    always @(negedge clk) begin
        if (count_en === 1'b1) begin
            m_e = -1;
            if (exp_en_q.size() > 0) m_e = exp_en_q.pop_front();
            checks++;
            if (cyc !== m_e) begin
                errors++;
                $display("FAIL count_en: seen at cycle %0d, expected %0d",
                         cyc, m_e);
            end
            checks++;
            if (prev_en === 1'b1) begin
                errors++;
                $display("FAIL en_duty: count_en high twice, cycle %0d",
                         cyc);
            end
            last_en = cyc;
        end
        if (lap_latch === 1'b1) begin
            m_e = -1;
            if (exp_lap_q.size() > 0) m_e = exp_lap_q.pop_front();
            checks++;
            if (cyc !== m_e) begin
                errors++;
                $display("FAIL lap_latch: seen at cycle %0d, expected %0d",
                         cyc, m_e);
            end
        end
        if (count_clr === 1'b1) begin
            m_e = -1;
            if (exp_clr_q.size() > 0) m_e = exp_clr_q.pop_front();
            checks++;
            if (cyc !== m_e) begin
                errors++;
                $display("FAIL count_clr: seen at cycle %0d, expected %0d",
                         cyc, m_e);
            end
        end
        if (state !== prev_state) begin
            m_s.c = -1;
            m_s.v = 2'b00;
            if (exp_st_q.size() > 0) m_s = exp_st_q.pop_front();
            checks++;
            if (cyc !== m_s.c || state !== m_s.v) begin
                errors++;
                $display("FAIL state_chg: got %b at cycle %0d, expected %b at %0d",
                         state, cyc, m_s.v, m_s.c);
            end
            n_st++;
        end
        checks++;
        if (display_hold !== (state == 2'b11)) begin
            errors++;
            $display("FAIL hold: display_hold=%b with state=%b cycle %0d",
                     display_hold, state, cyc);
        end
        prev_state = state;
        prev_en    = count_en;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit hit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic model_en_until(input int c);
        while (running && next_en <= c) begin
            exp_en_q.push_back(next_en);
            next_en += TD;
        end
    endtask

    task automatic wait_to(input int c);
        model_en_until(c);
        while (cyc < c) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic press(input logic s, input logic l, input int hold);
        int k;
        k = cyc;
        btn_ss = s;
        btn_lr = l;
        wait_to(k + hold);
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        wait_to(k + 16);
    endtask

    task automatic go_pause(input int p);
        model_en_until(p - 1);
        rem = next_en - p;
        running = 1'b0;
        exp_st_q.push_back('{p, 2'b10});
    endtask

    task automatic go_resume(input int s);
        exp_st_q.push_back('{s, 2'b01});
        running = 1'b1;
        next_en = s + ((rem == 0) ? TD : rem);
    endtask

    task automatic test_reset();
        int k;
        int bad;
        bad = 0;
        reset_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            btn_ss = i[0];
            btn_lr = ~i[0];
            @(negedge clk);
            #1;
            checks++;
            if ({count_en, count_clr, lap_latch, display_hold, state} !== 6'b0) begin
                errors++;
                $display("FAIL reset_out: outputs %b, required 000000",
                         {count_en, count_clr, lap_latch, display_hold, state});
            end
        end
        btn_ss = 1'b0;
        btn_lr = 1'b0;
        reset_n = 1'b1;
        k = cyc;
        wait_to(k + 10);
        checks++;
        if (state !== 2'b00 || n_st !== 0) begin
            errors++;
            $display("FAIL reset_idle: state=%b changes=%0d, required 00/0",
                     state, n_st);
        end
    endtask

    task automatic test_start();
        int k;
        int n0;
        k = cyc;
        n0 = n_st;
        exp_st_q.push_back('{k + 7, 2'b01});
        running = 1'b1;
        next_en = k + 7 + TD;
        press(1'b1, 1'b0, 10);
        wait_to(k + 30);
        checks++;
        if (state !== 2'b01 || n_st - n0 !== 1) begin
            errors++;
            $display("FAIL start: state=%b changes=%0d, required 01/1",
                     state, n_st - n0);
        end
        checks++;
        if (last_en !== k + 27) begin
            errors++;
            $display("FAIL start_cadence: last en %0d, required %0d",
                     last_en, k + 27);
        end
    endtask

    task automatic test_bounce();
        int k;
        int n0;
        k = cyc;
        n0 = n_st;
        btn_ss = 1'b1;
        wait_to(k + 2);
        btn_ss = 1'b0;
        wait_to(k + 3);
        btn_ss = 1'b1;
        wait_to(k + 5);
        btn_ss = 1'b0;
        wait_to(k + 20);
        checks++;
        if (state !== 2'b01 || n_st !== n0) begin
            errors++;
            $display("FAIL bounce_reject: state=%b changes=%0d, required 01/0",
                     state, n_st - n0);
        end
        k = cyc;
        go_pause(k + 7);
        press(1'b1, 1'b0, 4);
        wait_to(k + 20);
        checks++;
        if (state !== 2'b10 || n_st - n0 !== 1) begin
            errors++;
            $display("FAIL bounce_accept: state=%b changes=%0d, required 10/1",
                     state, n_st - n0);
        end
    endtask

    task automatic test_pause_resume();
        int k;
        int e;
        int s;
        k = cyc;
        go_resume(k + 7);
        press(1'b1, 1'b0, 4);
        e = next_en;
        while (e - 9 < cyc) e += TD;
        wait_to(e - 9);
        go_pause(e - 2);
        press(1'b1, 1'b0, 4);
        checks++;
        if (state !== 2'b10) begin
            errors++;
            $display("FAIL pause: state=%b, required 10", state);
        end
        k = cyc;
        s = k + 7;
        go_resume(s);
        btn_ss = 1'b1;
        wait_to(k + 4);
        btn_ss = 1'b0;
        wait_to(s + 2);
        checks++;
        if (last_en !== s + 2 || state !== 2'b01) begin
            errors++;
            $display("FAIL resume_frac: en at %0d state=%b, required %0d/01",
                     last_en, state, s + 2);
        end
        wait_to(k + 16);
    endtask

    task automatic test_lap();
        int k;
        int l;
        int n0;
        k = cyc;
        l = k + 7;
        n0 = n_st;
        exp_st_q.push_back('{l, 2'b11});
        exp_lap_q.push_back(l);
        btn_lr = 1'b1;
        wait_to(k + 4);
        btn_lr = 1'b0;
        wait_to(l);
        checks++;
        if (state !== 2'b11 || lap_latch !== 1'b1 || display_hold !== 1'b1) begin
            errors++;
            $display("FAIL lap_enter: state=%b latch=%b hold=%b, required 11/1/1",
                     state, lap_latch, display_hold);
        end
        wait_to(l + 1);
        checks++;
        if (lap_latch !== 1'b0 || display_hold !== 1'b1) begin
            errors++;
            $display("FAIL lap_pulse: latch=%b hold=%b, required 0/1",
                     lap_latch, display_hold);
        end
        wait_to(k + 20);
        k = cyc;
        l = k + 7;
        exp_st_q.push_back('{l, 2'b01});
        btn_lr = 1'b1;
        wait_to(k + 4);
        btn_lr = 1'b0;
        wait_to(l);
        checks++;
        if (state !== 2'b01 || display_hold !== 1'b0) begin
            errors++;
            $display("FAIL lap_exit: state=%b hold=%b, required 01/0",
                     state, display_hold);
        end
        wait_to(k + 16);
        checks++;
        if (n_st - n0 !== 2 || exp_lap_q.size() !== 0) begin
            errors++;
            $display("FAIL lap_count: changes=%0d pending=%0d, required 2/0",
                     n_st - n0, exp_lap_q.size());
        end
    endtask

    task automatic test_clear();
        int k;
        int c;
        int n0;
        k = cyc;
        go_pause(k + 7);
        press(1'b1, 1'b0, 4);
        k = cyc;
        c = k + 7;
        exp_st_q.push_back('{c, 2'b00});
        exp_clr_q.push_back(c);
        btn_lr = 1'b1;
        wait_to(k + 4);
        btn_lr = 1'b0;
        wait_to(c);
        checks++;
        if (state !== 2'b00 || count_clr !== 1'b1) begin
            errors++;
            $display("FAIL clear: state=%b clr=%b, required 00/1",
                     state, count_clr);
        end
        wait_to(c + 1);
        checks++;
        if (count_clr !== 1'b0) begin
            errors++;
            $display("FAIL clear_pulse: clr=%b, required 0", count_clr);
        end
        wait_to(k + 24);
        n0 = n_st;
        press(1'b0, 1'b1, 4);
        checks++;
        if (state !== 2'b00 || n_st !== n0) begin
            errors++;
            $display("FAIL idle_lr: state=%b changes=%0d, required 00/0",
                     state, n_st - n0);
        end
    endtask

    task automatic test_simultaneous();
        int k;
        int n0;
        k = cyc;
        exp_st_q.push_back('{k + 7, 2'b01});
        running = 1'b1;
        next_en = k + 7 + TD;
        press(1'b1, 1'b0, 4);
        k = cyc;
        n0 = n_st;
        go_pause(k + 7);
        press(1'b1, 1'b1, 4);
        checks++;
        if (state !== 2'b10 || display_hold !== 1'b0 || n_st - n0 !== 1) begin
            errors++;
            $display("FAIL simult: state=%b hold=%b changes=%0d, required 10/0/1",
                     state, display_hold, n_st - n0);
        end
        k = cyc;
        go_resume(k + 7);
        press(1'b1, 1'b0, 4);
    endtask

    task automatic test_reset_mid_run();
        int a;
        int b;
        a = cyc;
        exp_en_q.delete();
        running = 1'b0;
        exp_st_q.push_back('{a + 1, 2'b00});
        btn_ss = 1'b1;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({count_en, count_clr, lap_latch, display_hold, state} !== 6'b0) begin
            errors++;
            $display("FAIL async_reset: outputs %b, required 000000",
                     {count_en, count_clr, lap_latch, display_hold, state});
        end
        wait_to(a + 3);
        b = cyc;
        reset_n = 1'b1;
        exp_st_q.push_back('{b + 7, 2'b01});
        running = 1'b1;
        next_en = b + 7 + TD;
        wait_to(b + 10);
        btn_ss = 1'b0;
        wait_to(b + 24);
        checks++;
        if (state !== 2'b01 || last_en !== b + 23) begin
            errors++;
            $display("FAIL held_btn: state=%b last en %0d, required 01/%0d",
                     state, last_en, b + 23);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_start();
        test_bounce();
        test_pause_resume();
        test_lap();
        test_clear();
        test_simultaneous();
        test_reset_mid_run();
        checks++;
        if (exp_en_q.size() + exp_st_q.size() + exp_lap_q.size() +
            exp_clr_q.size() !== 0) begin
            errors++;
            $display("FAIL pending: en=%0d st=%0d lap=%0d clr=%0d, required 0",
                     exp_en_q.size(), exp_st_q.size(), exp_lap_q.size(),
                     exp_clr_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
